// File: rtl/mcu_pkg.sv
// Shared MCU definitions: data-memory responder FSM encoding and default widths/timing.
package mcu_pkg;

   localparam int MCU_DATA_W       = 16;
   localparam int MCU_WAIT_DEFAULT = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

endpackage

// File: rtl/mcu_dmem_array.sv
// Plain DEPTH x DATA_W data RAM with synchronous write and a registered read port.
module mcu_dmem_array #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 256,
   parameter int AW     = 8
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [AW-1:0]     i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Contents are deliberately never reset; the read register only moves on a read strobe.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      if (i_re) begin
         o_rdata <= r_mem[i_addr];
      end
   end

endmodule

// File: rtl/mcu_data_mem_responder.sv
// Wait-state data-memory responder for the MCU load/store port.
// Optional MCU_DMEM_STATS_EN adds saturating rd_count/wr_count access counters.
module mcu_data_mem_responder
   import mcu_pkg::*;
#(
   parameter int DATA_W      = MCU_DATA_W,
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = MCU_WAIT_DEFAULT
) (
   input  logic              clk,
   input  logic              Clear,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_error
`ifdef MCU_DMEM_STATS_EN
   ,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
`endif
);

   localparam int              RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   dmem_state_t       r_state;
   dmem_state_t       w_nextState;
   logic [3:0]        r_count;
   logic              r_write;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_rdOk;
   logic              r_error;

   logic              w_accept;
   logic              w_enterResp;
   logic              w_curWrite;
   logic [ADDR_W-1:0] w_curAddr;
   logic [DATA_W-1:0] w_curWdata;
   logic              w_inRange;
   logic              w_ramWe;
   logic              w_ramRe;
   logic [DATA_W-1:0] w_ramRdata;

   // With zero wait states the access commits on the accept edge, so it uses the live request.
   assign w_curWrite  = (r_state == IDLE) ? req_write : r_write;
   assign w_curAddr   = (r_state == IDLE) ? req_addr  : r_addr;
   assign w_curWdata  = (r_state == IDLE) ? req_wdata : r_wdata;
   assign w_inRange   = ({1'b0, w_curAddr} < DEPTH_L);

   assign w_accept    = (r_state == IDLE) && req_valid;
   assign w_enterResp = (w_nextState == RESP) && (r_state != RESP);
   assign w_ramWe     = w_enterResp && w_curWrite && w_inRange;
   assign w_ramRe     = w_enterResp && !w_curWrite && w_inRange;

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: if (req_valid) w_nextState = (WAIT_CYCLES == 0) ? RESP : WAIT;
         WAIT: if (r_count == 4'd1) w_nextState = RESP;
         RESP: if (rsp_ready) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge Clear) begin
      if (Clear) begin
         r_state <= IDLE;
         r_count <= '0;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdOk  <= 1'b0;
         r_error <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_count <= 4'(WAIT_CYCLES);
         end else if (r_state == WAIT) begin
            r_count <= r_count - 4'd1;
         end
         if (w_enterResp) begin
            r_rdOk  <= w_ramRe;
            r_error <= !w_inRange;
         end
      end
   end

   mcu_dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (RAM_AW)
   ) u_array (
      .i_clk   (clk),
      .i_we    (w_ramWe),
      .i_re    (w_ramRe),
      .i_addr  (w_curAddr[RAM_AW-1:0]),
      .i_wdata (w_curWdata),
      .o_rdata (w_ramRdata)
   );

   // Response fields are forced to zero outside RESP so leaving RESP clears them.
   assign req_ready = (r_state == IDLE);
   assign rsp_valid = (r_state == RESP);
   assign rsp_rdata = (rsp_valid && r_rdOk) ? w_ramRdata : '0;
   assign rsp_error = rsp_valid && r_error;

`ifdef MCU_DMEM_STATS_EN
   logic [15:0] r_rdCount;
   logic [15:0] r_wrCount;

   always_ff @(posedge clk or posedge Clear) begin
      if (Clear) begin
         r_rdCount <= '0;
         r_wrCount <= '0;
      end else begin
         if (w_ramRe && (r_rdCount != 16'hFFFF)) r_rdCount <= r_rdCount + 16'd1;
         if (w_ramWe && (r_wrCount != 16'hFFFF)) r_wrCount <= r_wrCount + 16'd1;
      end
   end

   assign rd_count = r_rdCount;
   assign wr_count = r_wrCount;
`endif

endmodule

// File: tb/tb_mcu_data_mem_responder.sv
// Self-checking bench for mcu_data_mem_responder: vector table plus scoreboard and
// hand-written sequences for backpressure, abort-in-WAIT and reset-during-RESP.
module tb_mcu_data_mem_responder;

   localparam int TB_DATA_W = 16;
   localparam int TB_ADDR_W = 8;
   localparam int TB_DEPTH  = 128;
   localparam int TB_WAIT   = 2;
   localparam int NUM_VECS  = 13;

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic [15:0] expRdata;
      logic        expErr;
   } vec_t;

   typedef struct {
      logic [15:0] rdata;
      logic        err;
   } expect_t;

   logic                 clk;
   logic                 Clear;
   logic                 req_valid;
   logic                 req_write;
   logic [TB_ADDR_W-1:0] req_addr;
   logic [TB_DATA_W-1:0] req_wdata;
   logic                 req_ready;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [TB_DATA_W-1:0] rsp_rdata;
   logic                 rsp_error;
`ifdef MCU_DMEM_STATS_EN
   logic [15:0]          rd_count;
   logic [15:0]          wr_count;
   int                   expRd;
   int                   expWr;
`endif

   int      nCompared;
   int      nMismatched;
   logic    busyJunk;
   int      seqLat;
   vec_t    vecs [NUM_VECS];
   expect_t sbQ [$];

   mcu_data_mem_responder #(
      .DATA_W      (TB_DATA_W),
      .ADDR_W      (TB_ADDR_W),
      .DEPTH       (TB_DEPTH),
      .WAIT_CYCLES (TB_WAIT)
   ) dut (
      .clk       (clk),
      .Clear     (Clear),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_error (rsp_error)
`ifdef MCU_DMEM_STATS_EN
      ,
      .rd_count  (rd_count),
      .wr_count  (wr_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global watchdog so a stuck DUT can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkBit(input string name, input logic act, input logic exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic checkWord(input string name, input logic [15:0] act, input logic [15:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic checkInt(input string name, input int act, input int exp);
      nCompared++;
      if (act != exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Pops the oldest expected response and compares it with what the DUT presents now.
   task automatic checkOutput();
      expect_t e;
      if (sbQ.size() == 0) begin
         checkInt("sb_underflow", 0, 1);
         return;
      end
      e = sbQ.pop_front();
      checkBit("rsp_valid", rsp_valid, 1'b1);
      checkWord("rsp_rdata", rsp_rdata, e.rdata);
      checkBit("rsp_error", rsp_error, e.err);
   endtask

   // Drives one request from a negedge, waits for its response, holds rsp_ready low for
   // 'hold' response cycles, then completes the handshake and checks the return to IDLE.
   task automatic applyStimulus(input logic wr, input logic [7:0] a, input logic [15:0] d,
                                input logic [15:0] expD, input logic expE, input int hold);
      int      lat;
      expect_t e;
      e.rdata = expD;
      e.err   = expE;
      sbQ.push_back(e);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = d;
      rsp_ready = (hold == 0);
      checkBit("req_ready_idle", req_ready, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      req_write = ~wr;
      req_addr  = ~a;
      req_wdata = ~d;
      if (busyJunk) begin
         req_valid = 1'b1;
         req_write = 1'b1;
         req_addr  = a;
         req_wdata = 16'hDEAD;
      end
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         checkBit("busy_req_ready", req_ready, 1'b0);
         @(negedge clk);
         lat++;
      end
      if (!rsp_valid) begin
         checkInt("rsp_timeout", lat, TB_WAIT + 1);
         e = sbQ.pop_front();
         req_valid = 1'b0;
         return;
      end
      checkInt("latency", lat, TB_WAIT + 1);
`ifdef MCU_DMEM_STATS_EN
      if (!expE) begin
         if (wr) expWr++;
         else    expRd++;
      end
`endif
      for (int i = 0; i < hold; i++) begin
         checkBit("hold_valid", rsp_valid, 1'b1);
         checkWord("hold_rdata", rsp_rdata, expD);
         checkBit("hold_error", rsp_error, expE);
         checkBit("hold_req_ready", req_ready, 1'b0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      checkOutput();
      @(negedge clk);
      req_valid = 1'b0;
      checkBit("post_rsp_valid", rsp_valid, 1'b0);
      checkWord("post_rsp_rdata", rsp_rdata, 16'h0000);
      checkBit("post_rsp_error", rsp_error, 1'b0);
      checkBit("post_req_ready", req_ready, 1'b1);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 8'h10, 16'hBEEF, 16'h0000, 1'b0};
      vecs[1]  = '{1'b0, 8'h10, 16'h0000, 16'hBEEF, 1'b0};
      vecs[2]  = '{1'b1, 8'h20, 16'h1357, 16'h0000, 1'b0};
      vecs[3]  = '{1'b1, 8'h05, 16'h5555, 16'h0000, 1'b0};
      vecs[4]  = '{1'b0, 8'h05, 16'h0000, 16'h5555, 1'b0};
      vecs[5]  = '{1'b0, 8'h90, 16'h0000, 16'h0000, 1'b1};
      vecs[6]  = '{1'b1, 8'h90, 16'h1234, 16'h0000, 1'b1};
      vecs[7]  = '{1'b0, 8'h10, 16'h0000, 16'hBEEF, 1'b0};
      vecs[8]  = '{1'b1, 8'h7F, 16'hFFFF, 16'h0000, 1'b0};
      vecs[9]  = '{1'b0, 8'h7F, 16'h0000, 16'hFFFF, 1'b0};
      vecs[10] = '{1'b0, 8'h80, 16'h0000, 16'h0000, 1'b1};
      vecs[11] = '{1'b1, 8'h00, 16'h0001, 16'h0000, 1'b0};
      vecs[12] = '{1'b0, 8'h00, 16'h0000, 16'h0001, 1'b0};

      nCompared   = 0;
      nMismatched = 0;
      busyJunk    = 1'b0;
`ifdef MCU_DMEM_STATS_EN
      expRd = 0;
      expWr = 0;
`endif
      Clear     = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      Clear = 1'b0;
      @(negedge clk);
      checkBit("reset_req_ready", req_ready, 1'b1);
      checkBit("reset_rsp_valid", rsp_valid, 1'b0);
      checkWord("reset_rsp_rdata", rsp_rdata, 16'h0000);
      checkBit("reset_rsp_error", rsp_error, 1'b0);
`ifdef MCU_DMEM_STATS_EN
      checkWord("reset_rd_count", rd_count, 16'h0000);
      checkWord("reset_wr_count", wr_count, 16'h0000);
`endif

      for (int i = 0; i < NUM_VECS; i++) begin
         applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                       vecs[i].expRdata, vecs[i].expErr, 0);
      end

`ifdef MCU_DMEM_STATS_EN
      checkWord("stats_rd_count", rd_count, 16'(expRd));
      checkWord("stats_wr_count", wr_count, 16'(expWr));
`endif

      // Backpressure: response held for 5 cycles while a clobbering store is presented.
      busyJunk = 1'b1;
      applyStimulus(1'b0, 8'h20, 16'h0000, 16'h1357, 1'b0, 5);
      busyJunk = 1'b0;
      applyStimulus(1'b0, 8'h20, 16'h0000, 16'h1357, 1'b0, 0);

      // Abort a store one cycle into WAIT; memory must keep the earlier value.
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 8'h05;
      req_wdata = 16'hAAAA;
      rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      checkBit("abort_wait_req_ready", req_ready, 1'b0);
      checkBit("abort_wait_rsp_valid", rsp_valid, 1'b0);
      Clear = 1'b1;
      @(negedge clk);
      Clear = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checkBit("abort_no_rsp", rsp_valid, 1'b0);
         @(negedge clk);
      end
`ifdef MCU_DMEM_STATS_EN
      expRd = 0;
      expWr = 0;
      checkWord("abort_rd_count", rd_count, 16'h0000);
      checkWord("abort_wr_count", wr_count, 16'h0000);
`endif
      applyStimulus(1'b0, 8'h05, 16'h0000, 16'h5555, 1'b0, 0);

      // Clear during RESP drops the response but the committed store stays.
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 8'h40;
      req_wdata = 16'hC0DE;
      rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      seqLat = 1;
      while (!rsp_valid && seqLat < 40) begin
         @(negedge clk);
         seqLat++;
      end
      checkInt("resp_clear_latency", seqLat, TB_WAIT + 1);
      Clear = 1'b1;
      #1;
      checkBit("resp_clear_drops_rsp", rsp_valid, 1'b0);
      checkBit("resp_clear_req_ready", req_ready, 1'b1);
      @(negedge clk);
      Clear = 1'b0;
      @(negedge clk);
      applyStimulus(1'b0, 8'h40, 16'h0000, 16'hC0DE, 1'b0, 0);

      checkInt("sb_empty", sbQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
